// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 raster constants and the shared coordinate type
package vga_timing_pkg;
  localparam int H_VISIBLE_D = 640;
  localparam int H_FRONT_D   = 16;
  localparam int H_SYNC_D    = 96;
  localparam int H_BACK_D    = 48;
  localparam int H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
  localparam int V_VISIBLE_D = 480;
  localparam int V_FRONT_D   = 10;
  localparam int V_SYNC_D    = 2;
  localparam int V_BACK_D    = 33;
  localparam int V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: depth-N, 2-bit shift register with clock enable; stages reset to 1 (sync idle)
module vga_sync_delay #(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("vga_sync_delay: DEPTH must be 1..8");
  end
  logic [DEPTH-1:0][1:0] sr_q, sr_d;
  // shift one stage per enabled cycle, newest sample in stage 0
  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  // stage registers hold while the enable is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sr_q <= '1;
    else if (ce_i) sr_q <= sr_d;
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered blank/sync/frame decode; optional sync delay via VGA_PIPE_DELAY_EN
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_D,
  parameter int H_FRONT    = H_FRONT_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BACK     = H_BACK_D,
  parameter int V_VISIBLE  = V_VISIBLE_D,
  parameter int V_FRONT    = V_FRONT_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BACK     = V_BACK_D,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pixel_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_VISIBLE + H_FRONT;
  localparam int H_SE    = H_SS + H_SYNC;
  localparam int V_SS    = V_VISIBLE + V_FRONT;
  localparam int V_SE    = V_SS + V_SYNC;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  localparam coord_t H_MAX = coord_t'(H_TOTAL - 1);
  localparam coord_t V_MAX = coord_t'(V_TOTAL - 1);
  coord_t x_q, x_d, y_q, y_d;
  logic   blank_q, blank_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  // next count and its decode, so outputs register alongside the count they describe
  always_comb begin
    x_d     = (x_q == H_MAX) ? '0 : x_q + coord_t'(1);
    y_d     = (x_q != H_MAX) ? y_q : (y_q == V_MAX) ? '0 : y_q + coord_t'(1);
    blank_d = int'(x_d) < H_VISIBLE && int'(y_d) < V_VISIBLE;
    hs_d    = !(int'(x_d) >= H_SS && int'(x_d) < H_SE);
    vs_d    = !(int'(y_d) >= V_SS && int'(y_d) < V_SE);
    fs_d    = x_d == '0 && y_d == '0;
  end
  // reset parks the raster at the last pixel so the first enabled edge starts a full frame
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q     <= H_MAX;
      y_q     <= V_MAX;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else if (pixel_ce) begin
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;
`ifdef VGA_PIPE_DELAY_EN
  logic [1:0] sync_q;
  vga_sync_delay #(.DEPTH(PIPE_DELAY)) u_sync_delay (
    .clk_i (vga_clk),
    .rst_ni(reset_n),
    .ce_i  (pixel_ce),
    .d_i   ({hs_q, vs_q}),
    .q_o   (sync_q)
  );
  assign hs = sync_q[1];
  assign vs = sync_q[0];
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced raster (24x10) so whole frames fit in a short run
module tb_vga_timing_gen;
  localparam int H_VIS = 16, H_FR = 2, H_SY = 3, H_BK = 3;
  localparam int V_VIS = 6, V_FR = 1, V_SY = 2, V_BK = 1;
  localparam int H_T = H_VIS + H_FR + H_SY + H_BK;
  localparam int V_T = V_VIS + V_FR + V_SY + V_BK;
`ifdef VGA_PIPE_DELAY_EN
  localparam int PD = 2;
`else
  localparam int PD = 0;
`endif
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic       h;
    logic       v;
    logic       f;
  } obs_t;
  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_ce = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, frame_start;
  int total = 0, bad = 0;
  int mx, my, ec, last_fs, exp_period, hrun, vrun;
  logic       prev_fs;
  logic [1:0] dq[$];
  obs_t       sb[$];
  vga_timing_gen #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FR), .H_SYNC(H_SY), .H_BACK(H_BK),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FR), .V_SYNC(V_SY), .V_BACK(V_BK),
    .PIPE_DELAY(2)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .pixel_ce(pixel_ce),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
    .frame_start(frame_start)
  );
  always #5 vga_clk = ~vga_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic obs_t model_out();
    obs_t o;
    o.x = 10'(mx);
    o.y = 10'(my);
    o.b = mx < H_VIS && my < V_VIS;
    o.h = dq[PD][1];
    o.v = dq[PD][0];
    o.f = mx == 0 && my == 0;
    return o;
  endfunction
  task automatic model_reset();
    mx = H_T - 1;
    my = V_T - 1;
    dq.delete();
    repeat (PD + 1) dq.push_back(2'b11);
    sb.delete();
    last_fs = -1;
    prev_fs = 1'b0;
    hrun = 0;
    vrun = 0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_x"}, 32'(DrawX), H_T - 1);
    chk({tag, "_y"}, 32'(DrawY), V_T - 1);
    chk({tag, "_blank"}, 32'(blank), 0);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_fs"}, 32'(frame_start), 0);
  endtask
  task automatic step(input logic ce);
    obs_t e, o;
    int px;
    px = mx;
    pixel_ce = ce;
    if (ce) begin
      mx = (mx == H_T - 1) ? 0 : mx + 1;
      if (mx == 0) my = (my == V_T - 1) ? 0 : my + 1;
      dq.push_front({!(mx >= H_VIS + H_FR && mx < H_VIS + H_FR + H_SY),
                     !(my >= V_VIS + V_FR && my < V_VIS + V_FR + V_SY)});
      void'(dq.pop_back());
    end
    sb.push_back(model_out());
    @(posedge vga_clk);
    #1;
    ec++;
    e = sb.pop_front();
    o = '{DrawX, DrawY, blank, hs, vs, frame_start};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL raster x/y/b/h/v/f observed=%0d/%0d/%b%b%b%b expected=%0d/%0d/%b%b%b%b",
             o.x, o.y, o.b, o.h, o.v, o.f, e.x, e.y, e.b, e.h, e.v, e.f);
    end
    if (ce && px == H_T - 1) chk("hwrap_x", 32'(DrawX), 0);
    if (mx == H_VIS - 1 && my == V_VIS - 1) chk("blank_last_vis", 32'(blank), 1);
    if (mx == H_VIS && my == 0) chk("blank_h_edge", 32'(blank), 0);
    if (mx == 0 && my == V_VIS) chk("blank_v_edge", 32'(blank), 0);
    if (frame_start && !prev_fs) begin
      if (last_fs >= 0) chk("frame_period", ec - last_fs, exp_period);
      last_fs = ec;
    end
    prev_fs = frame_start;
    if (ce) begin
      if (!hs) hrun++;
      else if (hrun > 0) begin
        chk("hs_width", hrun, H_SY);
        hrun = 0;
      end
      if (!vs) vrun++;
      else if (vrun > 0) begin
        chk("vs_width", vrun, V_SY * H_T);
        vrun = 0;
      end
    end
  endtask
  initial begin
    bit found;
    ec = 0;
    exp_period = H_T * V_T;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check_reset("por");
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(1'b0);
    step(1'b1);
    chk("first_x", 32'(DrawX), 0);
    chk("first_y", 32'(DrawY), 0);
    chk("first_blank", 32'(blank), 1);
    chk("first_fs", 32'(frame_start), 1);
    for (int i = 0; i < 3 * H_T * V_T; i++) step(1'b1);
    exp_period = 2 * H_T * V_T;
    last_fs = -1;
    for (int i = 0; i < 5 * H_T * V_T; i++) step(1'(i % 2 == 0));
    found = 1'b0;
    for (int i = 0; i < 4 * H_T && !found; i++) begin
      step(1'b1);
      found = DrawX == 10'd9;
    end
    chk("find_x9", 32'(found), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset("mid");
    model_reset();
    exp_period = H_T * V_T;
    @(negedge vga_clk);
    reset_n = 1'b1;
    step(1'b1);
    chk("rel_x", 32'(DrawX), 0);
    chk("rel_y", 32'(DrawY), 0);
    chk("rel_fs", 32'(frame_start), 1);
    for (int i = 0; i < 2 * H_T; i++) step(1'b1);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
